// File: rtl/pll_reset_ce_gen_if.sv
// Core control bundle: PLL lock and pause in; core reset, clock enables and run status out.
// Pure wiring, no latency of its own.
// No backpressure: every signal is a level or a single-cycle pulse.
interface pll_reset_ce_gen_if;
  logic pll_locked;
  logic pause;
  logic core_reset;
  logic ce_pix;
  logic ce_cpu;
  logic running;

  // Generator side: consumes lock/pause, drives reset and enables
  modport master (
    input  pll_locked,
    input  pause,
    output core_reset,
    output ce_pix,
    output ce_cpu,
    output running
  );

  // Core side: supplies lock/pause, receives reset and enables
  modport slave (
    output pll_locked,
    output pause,
    input  core_reset,
    input  ce_pix,
    input  ce_cpu,
    input  running
  );
endinterface

// File: rtl/pll_reset_ce_gen.sv
// Core reset sequencer plus pixel and fractional CPU clock-enable generator on clk_sys.
// Latency: lock rise -> HOLD in 3 edges, release RESET_HOLD edges later; lock loss -> reset in 3 edges.
// No backpressure; pause only freezes the CPU enable accumulator, the pixel enable keeps running.
module pll_reset_ce_gen #(
  parameter int RESET_HOLD = 1024,
  parameter int PIX_DIV    = 8,
  parameter int CPU_NUM    = 5,
  parameter int CPU_DEN    = 67
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  pll_reset_ce_gen_if.master bus
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int PIX_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int ACC_W  = $clog2(CPU_DEN) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
  localparam logic [ACC_W-1:0]  ACC_NUM   = ACC_W'(CPU_NUM);
  localparam logic [ACC_W-1:0]  ACC_DEN   = ACC_W'(CPU_DEN);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  logic [1:0]        r_sync;
  state_t            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_core_reset;
  logic              r_running;
  logic              r_ce_pix;
  logic              r_ce_cpu;

  logic              w_lock_s;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_run_nxt;
  logic [PIX_W-1:0]  w_pix_nxt;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_ce_cpu_nxt;

  assign w_lock_s = r_sync[1];

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], bus.pll_locked};
  end

  // Lock sequencer: any lock drop restarts the full hold count from zero
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = '0;
    case (r_state)
      S_WAIT_LOCK: if (w_lock_s) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (!w_lock_s)                    w_state_nxt = S_WAIT_LOCK;
        else if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_RUN;
        else                              w_hold_nxt  = r_hold_cnt + 1'b1;
      end
      S_RUN:   if (!w_lock_s) w_state_nxt = S_WAIT_LOCK;
      default: w_state_nxt = S_WAIT_LOCK;
    endcase
  end

  assign w_run_nxt = (w_state_nxt == S_RUN);

  // Pixel divider restarts at 0 on RUN entry so the first pulse lands PIX_DIV-1 cycles after release
  always_comb begin
    w_pix_nxt = '0;
    if (w_run_nxt && (r_state == S_RUN) && (r_pix_cnt != PIX_LAST))
      w_pix_nxt = r_pix_cnt + 1'b1;
  end

  // Fractional CPU enable: phase accumulator, carry out is the pulse; pause freezes the phase
  always_comb begin
    w_acc_sum    = r_acc + ACC_NUM;
    w_acc_nxt    = r_acc;
    w_ce_cpu_nxt = 1'b0;
    if (!w_run_nxt) begin
      w_acc_nxt = '0;
    end else if (!bus.pause) begin
      if (w_acc_sum >= ACC_DEN) begin
        w_acc_nxt    = w_acc_sum - ACC_DEN;
        w_ce_cpu_nxt = 1'b1;
      end else begin
        w_acc_nxt = w_acc_sum;
      end
    end
  end

  // State, counters and registered outputs; all outputs derive from next-state so lock loss wins
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_WAIT_LOCK;
      r_hold_cnt   <= '0;
      r_pix_cnt    <= '0;
      r_acc        <= '0;
      r_core_reset <= 1'b1;
      r_running    <= 1'b0;
      r_ce_pix     <= 1'b0;
      r_ce_cpu     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_pix_cnt    <= w_pix_nxt;
      r_acc        <= w_acc_nxt;
      r_core_reset <= !w_run_nxt;
      r_running    <= w_run_nxt;
      r_ce_pix     <= w_run_nxt && (w_pix_nxt == PIX_LAST);
      r_ce_cpu     <= w_ce_cpu_nxt;
    end
  end

  assign bus.core_reset = r_core_reset;
  assign bus.running    = r_running;
  assign bus.ce_pix     = r_ce_pix;
  assign bus.ce_cpu     = r_ce_cpu;

endmodule
